// File: rtl/lv_flt_pkg.sv
// Shared types and constants for the LV fault filter.
// Fault bit order matches the LV control FSM error inputs.
package lv_flt_pkg;

   typedef enum logic [1:0] {
      CLR_IDLE = 2'd0,
      CLR_CLR  = 2'd1,
      CLR_ACK  = 2'd2
   } clr_st_e;

   localparam int FLT_OW_COM  = 0;
   localparam int FLT_SPI     = 1;
   localparam int FLT_CRC_WD  = 2;
   localparam int FLT_PWM     = 3;
   localparam int FLT_UV_VCC  = 4;
   localparam int FLT_OV_VCC  = 5;
   localparam int FLT_UV_VDD  = 6;
   localparam int FLT_OV_VDD  = 7;
   localparam int FLT_OT      = 8;
   localparam int FLT_HV_UV   = 9;
   localparam int FLT_HV_OV   = 10;
   localparam int FLT_HV_OC   = 11;
   localparam int FLT_HV_SCP  = 12;

   localparam logic [7:0] DGL_DEF = 8'd4;

endpackage

// File: rtl/lv_flt_dgl_cnt.sv
// Single-channel deglitch counter with fault latch.
// Rises slowly (saturating count), drops instantly; latch held until cleared.
module lv_flt_dgl_cnt
   import lv_flt_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_raw,
   input  logic             i_mask,
   input  logic             i_clr,
   input  logic [CNT_W-1:0] i_thr,
   output logic             o_lat
);

   logic [CNT_W-1:0] thr;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lat_q, lat_d;
   logic             filt_now;
   logic             set;

   assign thr = (i_thr == '0) ? CNT_W'(1) : i_thr;

   // A count above a freshly lowered threshold collapses onto it.
   always_comb begin
      cnt_d = '0;
      if (i_raw) begin
         if (cnt_q >= thr) cnt_d = thr;
         else              cnt_d = cnt_q + 1'b1;
      end
   end

   assign filt_now = (cnt_q >= thr);
   assign set      = (cnt_d == thr) & ~i_mask;

   always_comb begin
      lat_d = set | (lat_q & ~(i_clr & ~filt_now));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
         lat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         lat_q <= lat_d;
      end
   end

   assign o_lat = lat_q;

endmodule

// File: rtl/lv_fault_filter.sv
// LV fault front end: deglitch, latch, 4-phase clear, first-fault capture.
// Define LV_FLT_SYNC_EN to add 2-flop synchronizers on raw faults and clear request.
module lv_fault_filter
   import lv_flt_pkg::*;
#(
   parameter int FLT_NUM = 13,
   parameter int CNT_W   = 8,
   parameter int IDX_W   = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [FLT_NUM-1:0] i_flt_raw,
   input  logic [FLT_NUM-1:0] i_flt_mask,
   input  logic [CNT_W-1:0]   i_dgl_cyc,
   input  logic               i_clr_req,
   output logic               o_clr_ack,
   output logic [FLT_NUM-1:0] o_flt_lat,
   output logic               o_flt_any,
   output logic [IDX_W-1:0]   o_flt_first,
   output logic               o_flt_first_vld
);

   logic [FLT_NUM-1:0] raw_s;
   logic               req_s;

`ifdef LV_FLT_SYNC_EN
   logic [FLT_NUM-1:0] raw_s1_q, raw_s2_q;
   logic               req_s1_q, req_s2_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         raw_s1_q <= '0;
         raw_s2_q <= '0;
         req_s1_q <= 1'b0;
         req_s2_q <= 1'b0;
      end else begin
         raw_s1_q <= i_flt_raw;
         raw_s2_q <= raw_s1_q;
         req_s1_q <= i_clr_req;
         req_s2_q <= req_s1_q;
      end
   end

   assign raw_s = raw_s2_q;
   assign req_s = req_s2_q;
`else
   assign raw_s = i_flt_raw;
   assign req_s = i_clr_req;
`endif

   clr_st_e st_q;
   logic    ack_q;
   logic    clr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         st_q  <= CLR_IDLE;
         ack_q <= 1'b0;
      end else begin
         unique case (st_q)
            CLR_IDLE: if (req_s) st_q <= CLR_CLR;
            CLR_CLR: begin
               st_q  <= CLR_ACK;
               ack_q <= 1'b1;
            end
            CLR_ACK: if (!req_s) begin
               st_q  <= CLR_IDLE;
               ack_q <= 1'b0;
            end
            default: begin
               st_q  <= CLR_IDLE;
               ack_q <= 1'b0;
            end
         endcase
      end
   end

   assign clr       = (st_q == CLR_CLR);
   assign o_clr_ack = ack_q;

   logic [FLT_NUM-1:0] lat;

   for (genvar g = 0; g < FLT_NUM; g++) begin : g_ch
      lv_flt_dgl_cnt #(.CNT_W(CNT_W)) u_cnt (
         .i_clk  (i_clk),
         .i_rst  (i_rst),
         .i_raw  (raw_s[g]),
         .i_mask (i_flt_mask[g]),
         .i_clr  (clr),
         .i_thr  (i_dgl_cyc),
         .o_lat  (lat[g])
      );
   end

   assign o_flt_lat = lat;

   logic [IDX_W-1:0] first_d, first_q;
   logic             vld_q, any_q;

   always_comb begin
      first_d = '0;
      for (int i = FLT_NUM - 1; i >= 0; i--) begin
         if (lat[i]) first_d = IDX_W'(i);
      end
   end

   // Captured only on the empty-to-nonempty transition of the latch vector.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         any_q   <= 1'b0;
         first_q <= '0;
         vld_q   <= 1'b0;
      end else begin
         any_q <= |lat;
         if (lat == '0) begin
            first_q <= '0;
            vld_q   <= 1'b0;
         end else if (!vld_q) begin
            first_q <= first_d;
            vld_q   <= 1'b1;
         end
      end
   end

   assign o_flt_any       = any_q;
   assign o_flt_first     = first_q;
   assign o_flt_first_vld = vld_q;

endmodule

// File: tb/tb_lv_fault_filter.sv
// Directed self-checking bench for lv_fault_filter (default build, no sync).
module tb_lv_fault_filter;

   logic        clk;
   logic        rst;
   logic [12:0] raw;
   logic [12:0] mask;
   logic [7:0]  dgl;
   logic        req;
   logic        ack;
   logic [12:0] lat;
   logic        any;
   logic [3:0]  first;
   logic        vld;

   int n_chk = 0;
   int n_bad = 0;

   lv_fault_filter dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_flt_raw       (raw),
      .i_flt_mask      (mask),
      .i_dgl_cyc       (dgl),
      .i_clr_req       (req),
      .o_clr_ack       (ack),
      .o_flt_lat       (lat),
      .o_flt_any       (any),
      .o_flt_first     (first),
      .o_flt_first_vld (vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_clear(input string tag, input logic [12:0] lat_exp);
      req = 1'b1;
      step(1);
      chk({tag, "_ack_clr"}, 32'(ack), 32'd0);
      step(1);
      chk({tag, "_ack_hi"}, 32'(ack), 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
      step(2);
      chk({tag, "_ack_hold"}, 32'(ack), 32'd1);
      req = 1'b0;
      step(1);
      chk({tag, "_ack_lo"}, 32'(ack), 32'd0);
   endtask

   initial begin
      rst  = 1'b1;
      raw  = '0;
      mask = '0;
      dgl  = 8'd4;
      req  = 1'b0;
      step(2);
      chk("rst_lat", 32'(lat), 32'd0);
      chk("rst_any", 32'(any), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_first", 32'(first), 32'd0);
      chk("rst_vld", 32'(vld), 32'd0);
      rst = 1'b0;
      step(1);

      // short pulse, then full-length fault on channel 3
      raw[3] = 1'b1;
      step(3);
      raw[3] = 1'b0;
      step(1);
      chk("short_pulse", 32'(lat), 32'd0);
      raw[3] = 1'b1;
      step(3);
      chk("ch3_pre", 32'(lat), 32'd0);
      step(1);
      chk("ch3_lat", 32'(lat), 32'h0008);
      chk("ch3_any_late", 32'(any), 32'd0);
      step(1);
      chk("ch3_any", 32'(any), 32'd1);
      chk("ch3_first", 32'(first), 32'd3);
      chk("ch3_vld", 32'(vld), 32'd1);
      raw[3] = 1'b0;
      step(1);
      do_clear("clr1", 13'h0000);
      chk("clr1_vld", 32'(vld), 32'd0);

      // two channels rising together
      dgl = 8'd2;
      raw[5] = 1'b1;
      raw[9] = 1'b1;
      step(2);
      chk("dual_lat", 32'(lat), 32'h0220);
      step(1);
      chk("dual_first", 32'(first), 32'd5);
      raw = '0;
      step(1);
      do_clear("clr2", 13'h0000);
      chk("clr2_first", 32'(first), 32'd0);

      // masked channel keeps counting but cannot latch
      dgl = 8'd1;
      mask[7] = 1'b1;
      raw[7] = 1'b1;
      step(20);
      chk("mask_lat", 32'(lat), 32'd0);
      mask[7] = 1'b0;
      step(1);
      chk("unmask_lat", 32'(lat), 32'h0080);
      raw[7] = 1'b0;
      step(1);
      do_clear("clr3", 13'h0000);
      step(1);

      // clear keeps a still-filtered channel
      raw[4] = 1'b1;
      step(1);
      chk("ch4_lat", 32'(lat), 32'h0010);
      step(1);
      chk("ch4_first", 32'(first), 32'd4);
      raw[2] = 1'b1;
      step(1);
      chk("ch2_lat", 32'(lat), 32'h0014);
      raw[2] = 1'b0;
      step(1);
      do_clear("clr4", 13'h0010);
      chk("clr4_first", 32'(first), 32'd4);
      chk("clr4_vld", 32'(vld), 32'd1);
      raw[4] = 1'b0;
      step(1);
      do_clear("clr5", 13'h0000);
      chk("clr5_vld", 32'(vld), 32'd0);
      chk("clr5_any", 32'(any), 32'd0);

      // zero threshold behaves as one
      dgl = 8'd0;
      raw[11] = 1'b1;
      step(1);
      raw[11] = 1'b0;
      chk("dgl0_lat", 32'(lat), 32'h0800);
      step(1);
      chk("dgl0_first", 32'(first), 32'd11);

      // reset in the middle of a handshake
      raw[11] = 1'b1;
      req = 1'b1;
      step(2);
      chk("mid_ack", 32'(ack), 32'd1);
      chk("mid_lat", 32'(lat), 32'h0800);
      rst = 1'b1;
      #1;
      chk("arst_ack", 32'(ack), 32'd0);
      chk("arst_lat", 32'(lat), 32'd0);
      chk("arst_any", 32'(any), 32'd0);
      chk("arst_vld", 32'(vld), 32'd0);
      raw[11] = 1'b0;
      step(1);
      rst = 1'b0;
      step(1);
      chk("rel_ack0", 32'(ack), 32'd0);
      step(1);
      chk("rel_ack1", 32'(ack), 32'd1);
      req = 1'b0;
      step(1);
      chk("rel_ack_lo", 32'(ack), 32'd0);

      // lowering the threshold below a running count
      dgl = 8'd6;
      raw[0] = 1'b1;
      step(4);
      chk("thr_pre", 32'(lat), 32'd0);
      dgl = 8'd2;
      step(1);
      chk("thr_drop", 32'(lat), 32'h0001);
      raw[0] = 1'b0;
      step(2);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/lv_fault_filter.md
# lv_fault_filter

Low-voltage-die fault front end that sits directly upstream of the LV control FSM. It takes raw, asynchronous fault flags from the one-wire link, SPI, CRC watchdog, PWM checker and supply/HV monitors, and deglitches each one with a per-channel saturating counter. Each filtered fault is latched until a 4-phase clear handshake releases it. The block presents the ctrl FSM with a stable latched fault vector, a summary flag and first-fault capture.

## Interface
Parameters:
- FLT_NUM, 13, number of fault channels (bit order matches ctrl FSM error inputs, bit 0 = ow_com_err … bit 12 = hv_scp_err)
- CNT_W, 8, deglitch counter width
- IDX_W, 4, width of first-fault index; must satisfy 2^IDX_W ≥ FLT_NUM

Ports:
- i_clk  in  1  block clock
- i_rst  in  1  asynchronous, active-high reset
- i_flt_raw  in  FLT_NUM  raw fault flags, level-active high, may be asynchronous
- i_flt_mask  in  FLT_NUM  1 = channel may not set its latch (counter still runs)
- i_dgl_cyc  in  CNT_W  deglitch threshold in cycles, shared by all channels; 0 treated as 1
- i_clr_req  in  1  clear request, 4-phase level handshake
- o_clr_ack  out  1  clear acknowledge
- o_flt_lat  out  FLT_NUM  latched fault vector to ctrl FSM
- o_flt_any  out  1  OR of o_flt_lat, registered
- o_flt_first  out  IDX_W  index of first latched fault
- o_flt_first_vld  out  1  o_flt_first valid

## Operation
- Per channel, sampled raw s: s=1 → counter increments, saturating at i_dgl_cyc; s=0 → counter set to 0 the same edge (asymmetric, no release filter).
- Channel is "filtered" when the counter value after the edge equals the threshold. An unmasked filtered channel sets its o_flt_lat bit at that edge.
- Latch bits clear only via the clear handshake. Masking an already-set bit does not clear it.
- Clear FSM, states IDLE, CLR, ACK:
  - IDLE: i_clr_req=1 → CLR.
  - CLR, one cycle: clear every latch bit whose channel is not currently filtered; filtered channels stay set; → ACK.
  - ACK: o_clr_ack=1; i_clr_req=0 → IDLE (o_clr_ack low from the next cycle).
  - A requester that holds i_clr_req high sees no second clear until it drops the request and raises it again.
- Simultaneous set and clear on the same bit in CLR: set wins.
- First fault: when o_flt_lat goes from all-zero to non-zero, capture the lowest set index into o_flt_first and set o_flt_first_vld. It holds while any latch bit is set. It clears to 0/0 when all bits are cleared, and re-arms for the next fault.
- Reset: all counters 0, FSM IDLE; o_flt_lat=0, o_flt_any=0, o_clr_ack=0, o_flt_first=0, o_flt_first_vld=0; synchronizer flops 0.
- Reset asserted mid-handshake: FSM returns to IDLE and ack drops immediately (asynchronously). After release, a still-high i_clr_req starts a new clear.

## Timing
- Without sync: raw high sampled on N consecutive edges (N = max(i_dgl_cyc,1)) → o_flt_lat bit high after edge N; o_flt_any and o_flt_first[_vld] one edge later.
- With sync: add 2 cycles.
- Raw pulse shorter than N samples: no latch, counter back to 0.
- Clear: i_clr_req sampled high at edge k → CLR at k, bits cleared and ACK entered at edge k+1, o_clr_ack high after k+1.
- i_dgl_cyc changed while a counter is above the new value: counter saturates at, and is treated as equal to, the new threshold, so the latch sets on the next sample.

## Configuration
- LV_FLT_SYNC_EN defined: a 2-flop synchronizer on every i_flt_raw bit and on i_clr_req. Latency +2 cycles.
- Not defined: inputs sampled directly, and the integrator guarantees synchronous sources.

## Structure
- Shared package lv_flt_pkg holds:
  - the clear-FSM state enum (IDLE/CLR/ACK)
  - localparams for fault bit indices (FLT_OW_COM … FLT_HV_SCP)
  - the default deglitch value
- One sub-module, lv_flt_dgl_cnt: a single-channel counter plus latch, instantiated FLT_NUM times via generate.
- Clear FSM, summary and first-fault logic live in the top.

## Test plan
- i_dgl_cyc=4, raw[3] high 3 cycles then low → o_flt_lat=0; raw[3] high 4 cycles → o_flt_lat=13'h0008 after 4th edge, o_flt_first=3, vld=1.
- raw[5] and raw[9] rise same cycle, i_dgl_cyc=2 → o_flt_lat=13'h0220, o_flt_first=5.
- mask[7]=1, raw[7] held high 20 cycles with i_dgl_cyc=1 → o_flt_lat stays 0; unmask → bit 7 sets next edge.
- Latched bits 2 and 4, raw[4] still high, pulse i_clr_req → after CLR o_flt_lat=13'h0010, o_flt_first stays 4. Drop raw[4], clear again → o_flt_lat=0, vld=0, o_clr_ack follows 4-phase protocol.
- i_dgl_cyc=0 → fault latches after a 1-cycle raw pulse.
- Assert i_rst during ACK with faults latched → all outputs 0 immediately; i_clr_req high at reset release → new clear completes.
